// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types and widths for the data-memory bus sequencer and the
// load/store alignment stage that feeds it.
package mem_bus_ctrl_pkg;

    localparam int MB_ADDR_W  = 32;
    localparam int MB_DATA_W  = 32;
    localparam int MB_BE_W    = 4;
    localparam int MB_TIMES_W = 2;
    localparam int MB_CNT_W   = 8;

    typedef enum logic [1:0] {
        MB_IDLE = 2'd0,
        MB_REQ  = 2'd1,
        MB_WAIT = 2'd2,
        MB_DONE = 2'd3
    } mb_state_e;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [MB_CNT_W-1:0] mb_sat_inc(input logic [MB_CNT_W-1:0] v);
        return (v == {MB_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_bus_ctrl.sv
// Turns alignment-stage beat requests into single-beat req/gnt/rvalid
// transactions, with a pipeline stall and a sticky timeout error.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  res_n,
    input  logic                  write,
    input  logic [MB_TIMES_W-1:0] times_required,
    input  logic [MB_ADDR_W-1:0]  addr_post,
    input  logic [MB_BE_W-1:0]    data_be,
    input  logic [MB_DATA_W-1:0]  data_to_mem,
    output logic                  finished_once,
    output logic [MB_DATA_W-1:0]  data_from_mem,
    output logic                  stall,
    output logic                  bus_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [MB_ADDR_W-1:0]  mem_addr,
    output logic [MB_BE_W-1:0]    mem_be,
    output logic [MB_DATA_W-1:0]  mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [MB_DATA_W-1:0]  mem_rdata
);

    localparam logic [MB_CNT_W-1:0] TIMEOUT_C = MB_CNT_W'(TIMEOUT);

    mb_state_e              state_q, state_d;
    logic                   we_q, we_d;
    logic [MB_ADDR_W-1:0]   addr_q, addr_d;
    logic [MB_BE_W-1:0]     be_q, be_d;
    logic [MB_DATA_W-1:0]   wdata_q, wdata_d;
    logic [MB_DATA_W-1:0]   rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic [MB_CNT_W-1:0]    cnt_q, cnt_d;
    logic                   timed_out;

    // The counter equals the number of cycles spent since mem_req rose, so a
    // response arriving exactly TIMEOUT cycles later is still accepted.
    assign timed_out = (cnt_q == TIMEOUT_C);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= MB_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            MB_IDLE: begin
                if (times_required != '0) begin
                    we_d    = write;
                    addr_d  = addr_post;
                    be_d    = data_be;
                    wdata_d = data_to_mem;
                    cnt_d   = '0;
                    state_d = MB_REQ;
                end
            end
            MB_REQ: begin
                cnt_d = mb_sat_inc(cnt_q);
                if (timed_out) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = MB_DONE;
                end else if (mem_gnt) begin
                    state_d = MB_WAIT;
                end
            end
            MB_WAIT: begin
                cnt_d = mb_sat_inc(cnt_q);
                if (mem_rvalid) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = MB_DONE;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = MB_DONE;
                end
            end
            MB_DONE: begin
                state_d = MB_IDLE;
            end
            default: begin
                state_d = MB_IDLE;
            end
        endcase
    end

    assign mem_req       = (state_q == MB_REQ);
    assign mem_we        = mem_req & we_q;
    assign mem_addr      = addr_q;
    assign mem_be        = be_q;
    assign mem_wdata     = wdata_q;
    assign finished_once = (state_q == MB_DONE);
    assign data_from_mem = rdata_q;
    assign bus_err       = err_q;
    assign stall         = (times_required != '0) || (state_q != MB_IDLE);

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed plus randomized bench for mem_bus_ctrl; expectations come from
// per-beat arithmetic on grant/response delays against the timeout budget.
module tb_mem_bus_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    logic        write = 1'b0;
    logic [1:0]  times_required = 2'b00;
    logic [31:0] addr_post = '0;
    logic [3:0]  data_be = '0;
    logic [31:0] data_to_mem = '0;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        finished_once;
    logic [31:0] data_from_mem;
    logic        stall;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;

    int          checks = 0;
    int          failures = 0;
    int          beat_no = 0;
    logic [31:0] m_data = '0;
    logic        m_err = 1'b0;

    mem_bus_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .res_n(res_n), .write(write), .times_required(times_required),
        .addr_post(addr_post), .data_be(data_be), .data_to_mem(data_to_mem),
        .finished_once(finished_once), .data_from_mem(data_from_mem), .stall(stall),
        .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic edge_drive();
        @(posedge clk);
        #1;
    endtask

    // One beat from the cycle IDLE first sees times_required through the DONE
    // cycle. g = cycles of grant delay, r = cycles of response delay after grant.
    task automatic run_beat(input bit we, input logic [1:0] tr, input logic [31:0] addr,
                            input logic [3:0] be, input logic [31:0] wd, input logic [31:0] rd,
                            input int g, input int r, input bit noise);
        int req_cycles;
        int end_k;
        bit tout;
        if (g >= TO) begin
            tout = 1'b1; end_k = TO; req_cycles = TO + 1;
        end else begin
            req_cycles = g + 1;
            if (g + 1 + r <= TO) begin
                tout = 1'b0; end_k = g + 1 + r;
            end else begin
                tout = 1'b1; end_k = TO;
            end
        end
        edge_drive();
        times_required = tr; write = we; addr_post = addr; data_be = be; data_to_mem = wd;
        mem_gnt = 1'b0; mem_rvalid = noise; mem_rdata = $urandom;
        #2;
        chk("c0_req", mem_req, 0);
        chk("c0_fin", finished_once, 0);
        chk("c0_stall", stall, 1);
        chk("c0_dfm", data_from_mem, m_data);
        for (int k = 0; k <= end_k; k++) begin
            edge_drive();
            addr_post = $urandom; data_be = 4'($urandom); data_to_mem = $urandom; write = 1'($urandom);
            mem_gnt = (k == g);
            if (k < req_cycles) begin
                mem_rvalid = noise;
                mem_rdata = $urandom;
            end else begin
                mem_rvalid = (!tout && k == end_k);
                mem_rdata = mem_rvalid ? rd : $urandom;
            end
            #2;
            chk("req", mem_req, (k < req_cycles));
            if (k < req_cycles) begin
                chk("we", mem_we, we);
                chk("addr", mem_addr, addr);
                chk("be", mem_be, be);
                chk("wdata", mem_wdata, wd);
            end
            chk("fin_early", finished_once, 0);
            chk("stall_busy", stall, 1);
            chk("dfm_hold", data_from_mem, m_data);
            chk("err_busy", bus_err, m_err);
        end
        edge_drive();
        mem_gnt = 1'b0; mem_rvalid = noise; mem_rdata = $urandom;
        if (tout) begin
            m_data = '0; m_err = 1'b1;
        end else if (!we) begin
            m_data = rd;
        end
        #2;
        chk("fin_done", finished_once, 1);
        chk("req_done", mem_req, 0);
        chk("stall_done", stall, 1);
        chk("dfm_done", data_from_mem, m_data);
        chk("err_done", bus_err, m_err);
        $display("beat %0d we=%0b addr=%08h be=%h g=%0d r=%0d timeout=%0b dfm=%08h err=%0b",
                 beat_no, we, addr, be, g, r, tout, data_from_mem, bus_err);
        beat_no++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            edge_drive();
            times_required = 2'b00;
            mem_gnt = 1'($urandom); mem_rvalid = 1'($urandom); mem_rdata = $urandom;
            #2;
            chk("idle_stall", stall, 0);
            chk("idle_fin", finished_once, 0);
            chk("idle_req", mem_req, 0);
            chk("idle_dfm", data_from_mem, m_data);
            chk("idle_err", bus_err, m_err);
        end
    endtask

    initial begin
        // Reset values, and stall following times_required while in reset.
        #2;
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_fin", finished_once, 0);
        chk("rst_err", bus_err, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_be", mem_be, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_dfm", data_from_mem, 0);
        chk("rst_stall0", stall, 0);
        times_required = 2'b11;
        #1;
        chk("rst_stall1", stall, 1);
        times_required = 2'b00;
        edge_drive();
        res_n = 1'b1;
        idle(2);

        // Aligned load word, minimum latency.
        run_beat(1'b0, 2'b01, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0);
        idle(1);

        // Unaligned store, two back-to-back beats.
        run_beat(1'b1, 2'b10, 32'h100, 4'b1110, 32'hAABBCC00, 32'h11111111, 0, 0, 1'b0);
        run_beat(1'b1, 2'b01, 32'h104, 4'b0001, 32'h000000DD, 32'h22222222, 0, 0, 1'b0);
        idle(2);

        // Wait states: grant 3 late, response 2 late.
        run_beat(1'b0, 2'b01, 32'h200, 4'hF, 32'h0, 32'hCAFEF00D, 3, 2, 1'b0);
        // Grant and rvalid together in REQ: only the grant counts.
        run_beat(1'b0, 2'b01, 32'h204, 4'hF, 32'h0, 32'h12345678, 0, 1, 1'b1);
        // Response exactly at the timeout budget is accepted.
        run_beat(1'b0, 2'b01, 32'h208, 4'hF, 32'h0, 32'h0BADC0DE, 2, TO - 3, 1'b0);
        idle(1);
        // Response one cycle past the budget: timeout.
        run_beat(1'b0, 2'b01, 32'h20C, 4'hF, 32'h0, 32'h55555555, 2, TO - 2, 1'b0);
        idle(1);
        // Sticky error through a clean beat.
        run_beat(1'b0, 2'b01, 32'h300, 4'hF, 32'h0, 32'h600DF00D, 0, 0, 1'b0);
        // Timeout while never granted.
        run_beat(1'b1, 2'b01, 32'h304, 4'h3, 32'h9999, 32'h0, TO + 1, 0, 1'b0);
        idle(1);
        run_beat(1'b0, 2'b01, 32'h308, 4'hF, 32'h0, 32'hA5A5A5A5, 1, 0, 1'b0);

        // Reset asserted in WAIT; a late response must not complete a beat.
        edge_drive();
        times_required = 2'b01; write = 1'b0; addr_post = 32'h400; data_be = 4'hF;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        edge_drive();
        mem_gnt = 1'b1;
        #2;
        chk("rw_req", mem_req, 1);
        edge_drive();
        mem_gnt = 1'b0;
        res_n = 1'b0;
        times_required = 2'b00;
        m_data = '0; m_err = 1'b0;
        #1;
        chk("rw_req0", mem_req, 0);
        chk("rw_fin0", finished_once, 0);
        chk("rw_stall0", stall, 0);
        chk("rw_dfm0", data_from_mem, 0);
        chk("rw_err0", bus_err, 0);
        chk("rw_addr0", mem_addr, 0);
        edge_drive();
        res_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
            #2;
            chk("rw_late_fin", finished_once, 0);
            chk("rw_late_req", mem_req, 0);
            chk("rw_late_stall", stall, 0);
            chk("rw_late_dfm", data_from_mem, 0);
            edge_drive();
        end
        mem_rvalid = 1'b0;

        // Randomized beats.
        for (int n = 0; n < 40; n++) begin
            run_beat(1'($urandom), 2'($urandom_range(1, 3)), {$urandom, 2'b00} & 32'hFFFF_FFFC,
                     4'($urandom), $urandom, $urandom,
                     $urandom_range(0, TO + 1), $urandom_range(0, TO), 1'($urandom));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end
        idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
